aes_block_sequencer: RTL
========================

// Module: aes_block_sequencer
// PURPOSE
//  Parametrised HWPE control FSM for multi-block AES (ECB). Sits between the slave regfile, source/sink streamers and AES engine.
//  Per job: loads key once, then per block fetches plaintext, runs engine, stores ciphertext, advancing addresses.
//  Block count, key length and base addresses are latched at start. Streamer/engine interfaces are flat signals.
// PARAMETERS
//  ADDR_W      32  address width
//  BLK_CNT_W   16  width of block counter / num_blocks
//  BLOCK_BYTES 16  bytes per AES block; address stride per block
// PORTS
//  clk              in   1          clock
//  reset            in   1          synchronous active-high reset
//  clear            in   1          synchronous soft clear, same effect as reset
//  start_i          in   1          job start pulse (slave flags)
//  num_blocks_i     in   BLK_CNT_W  blocks in job
//  key_len_i        in   2          0:128b 1:192b 2:256b 3:reserved
//  key_base_i       in   ADDR_W     key address
//  src_base_i       in   ADDR_W     plaintext base
//  dst_base_i       in   ADDR_W     ciphertext base
//  src_req_start_o  out  1          source streamer request
//  src_addr_o       out  ADDR_W     source base_addr for current transfer
//  src_words_o      out  4          32-bit words in current source transfer
//  src_ready_i      in   1          source ready_start
//  src_done_i       in   1          source transfer done
//  dst_req_start_o  out  1          sink streamer request
//  dst_addr_o       out  ADDR_W     sink base_addr
//  dst_ready_i      in   1          sink ready_start
//  dst_done_i       in   1          sink transfer done
//  eng_clear_o      out  1          engine clear
//  eng_key_load_o   out  1          1-cycle: latch streamed key
//  eng_start_o      out  1          1-cycle: start block
//  eng_done_i       in   1          engine block done
//  busy_o           out  1          job in progress
//  done_o           out  1          1-cycle job-complete pulse
//  err_o            out  1          1-cycle pulse: start rejected
//  blk_cnt_o        out  BLK_CNT_W  blocks completed in current job
// BEHAVIOUR
//  Reset/clear: state IDLE; all outputs 0 except eng_clear_o=1; counters and latched config 0. Overrides any state.
//  States: IDLE, KEY_REQ, KEY_WAIT, SRC_REQ, SRC_WAIT, RUN, DST_REQ, DST_WAIT, FINISH.
//  IDLE: eng_clear_o=1. start_i with key_len_i==3 -> err_o next cycle, stay IDLE.
//   start_i with num_blocks_i==0 -> FINISH. Else latch config, blk_cnt=0 -> KEY_REQ.
//  start_i outside IDLE is ignored.
//  KEY_REQ: src_req_start_o=1, src_addr_o=key_base, src_words_o=4/6/8 per key_len. Leave on src_ready_i to KEY_WAIT.
//  KEY_WAIT: on src_done_i, eng_key_load_o=1 that cycle -> SRC_REQ.
//  SRC_REQ: src_req_start_o=1, src_addr_o=src_base+blk_cnt*BLOCK_BYTES, src_words_o=BLOCK_BYTES/4. src_ready_i -> SRC_WAIT.
//  SRC_WAIT: src_done_i -> eng_start_o=1 that cycle -> RUN.
//  RUN: eng_done_i -> DST_REQ.
//  DST_REQ: dst_req_start_o=1, dst_addr_o=dst_base+blk_cnt*BLOCK_BYTES. dst_ready_i -> DST_WAIT.
//  DST_WAIT: dst_done_i -> blk_cnt++. Then FINISH if new blk_cnt==num_blocks, else SRC_REQ.
//  FINISH: done_o=1 for exactly one cycle -> IDLE.
//  *_req_start_o is held high for the whole REQ state; it drops the cycle after ready is sampled.
//  Min per-block overhead is 5 cycles plus streamer/engine latency.
//  busy_o=1 in every state except IDLE.
//  Address arithmetic is ADDR_W modulo and wraps silently. blk_cnt*BLOCK_BYTES is computed full-width, then truncated.
//  blk_cnt_o holds its final value in IDLE until the next accepted start.
//  Done/ready inputs are sampled only in their own state; assertions elsewhere are ignored.
//  ready and done asserted together in a REQ state: only ready acts; done must be re-asserted in WAIT.
// TESTING
//  num_blocks=1, key_len=0, src=0x1000, dst=0x2000 -> key read 4 words, src 0x1000, dst 0x2000, done_o once, blk_cnt_o=1.
//  num_blocks=3, key_len=2 -> key read 8 words once; src 0x1000/0x1010/0x1020, dst 0x2000/0x2010/0x2020; 3 eng_start_o.
//  num_blocks=0 -> no requests; done_o pulse 2 cycles after start_i; busy_o high for 1 cycle.
//  key_len=3 -> err_o pulse, busy_o stays 0, no requests issued.
//  src_base=0xFFFF_FFF0, 2 blocks -> second src_addr_o=0x0000_0000.
//  clear asserted in RUN -> IDLE next cycle, outputs at reset values. A new start runs cleanly.

Source files
------------

// File: rtl/aes_block_sequencer.sv
// Control FSM for multi-block AES-ECB jobs: loads the key once, then streams
// plaintext in, runs the engine and streams ciphertext out for every block.
module aes_block_sequencer #(
  parameter int ADDR_W      = 32,
  parameter int BLK_CNT_W   = 16,
  parameter int BLOCK_BYTES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 start_i,
  input  logic [BLK_CNT_W-1:0] num_blocks_i,
  input  logic [1:0]           key_len_i,
  input  logic [ADDR_W-1:0]    key_base_i,
  input  logic [ADDR_W-1:0]    src_base_i,
  input  logic [ADDR_W-1:0]    dst_base_i,
  output logic                 src_req_start_o,
  output logic [ADDR_W-1:0]    src_addr_o,
  output logic [3:0]           src_words_o,
  input  logic                 src_ready_i,
  input  logic                 src_done_i,
  output logic                 dst_req_start_o,
  output logic [ADDR_W-1:0]    dst_addr_o,
  input  logic                 dst_ready_i,
  input  logic                 dst_done_i,
  output logic                 eng_clear_o,
  output logic                 eng_key_load_o,
  output logic                 eng_start_o,
  input  logic                 eng_done_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [BLK_CNT_W-1:0] blk_cnt_o
);

  localparam int         PROD_W      = ADDR_W + BLK_CNT_W;
  localparam logic [3:0] BLOCK_WORDS = 4'(BLOCK_BYTES / 4);

  typedef enum logic [3:0] {
    IDLE,
    KEY_REQ,
    KEY_WAIT,
    SRC_REQ,
    SRC_WAIT,
    RUN,
    DST_REQ,
    DST_WAIT,
    FINISH
  } state_t;

  state_t               state;
  logic [BLK_CNT_W-1:0] num_blocks_q;
  logic [1:0]           key_len_q;
  logic [ADDR_W-1:0]    key_base_q;
  logic [ADDR_W-1:0]    src_base_q;
  logic [ADDR_W-1:0]    dst_base_q;
  logic [BLK_CNT_W-1:0] blk_cnt_inc;

  // Product is formed at full width and then truncated, so addresses wrap mod 2**ADDR_W.
  function automatic logic [ADDR_W-1:0] blk_offset(input logic [BLK_CNT_W-1:0] n);
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(n) * PROD_W'(BLOCK_BYTES);
    return prod[ADDR_W-1:0];
  endfunction

  function automatic logic [3:0] key_words(input logic [1:0] len);
    case (len)
      2'd0:    return 4'd4;
      2'd1:    return 4'd6;
      default: return 4'd8;
    endcase
  endfunction

  // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    blk_cnt_inc = blk_cnt_o + BLK_CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state           <= IDLE;
      num_blocks_q    <= '0;
      key_len_q       <= '0;
      key_base_q      <= '0;
      src_base_q      <= '0;
      dst_base_q      <= '0;
      src_req_start_o <= 1'b0;
      src_addr_o      <= '0;
      src_words_o     <= '0;
      dst_req_start_o <= 1'b0;
      dst_addr_o      <= '0;
      eng_clear_o     <= 1'b1;
      eng_key_load_o  <= 1'b0;
      eng_start_o     <= 1'b0;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
      err_o           <= 1'b0;
      blk_cnt_o       <= '0;
    end else begin
      eng_key_load_o <= 1'b0;
      eng_start_o    <= 1'b0;
      done_o         <= 1'b0;
      err_o          <= 1'b0;

      case (state)
        IDLE: begin
          if (start_i) begin
            if (key_len_i == 2'd3) begin
              err_o <= 1'b1;
            end else if (num_blocks_i == '0) begin
              state       <= FINISH;
              busy_o      <= 1'b1;
              eng_clear_o <= 1'b0;
              blk_cnt_o   <= '0;
            end else begin
              state           <= KEY_REQ;
              busy_o          <= 1'b1;
              eng_clear_o     <= 1'b0;
              num_blocks_q    <= num_blocks_i;
              key_len_q       <= key_len_i;
              key_base_q      <= key_base_i;
              src_base_q      <= src_base_i;
              dst_base_q      <= dst_base_i;
              blk_cnt_o       <= '0;
              src_req_start_o <= 1'b1;
              src_addr_o      <= key_base_i;
              src_words_o     <= key_words(key_len_i);
            end
          end
        end

        KEY_REQ: begin
          if (src_ready_i) begin
            state           <= KEY_WAIT;
            src_req_start_o <= 1'b0;
          end
        end

        KEY_WAIT: begin
          if (src_done_i) begin
            state           <= SRC_REQ;
            eng_key_load_o  <= 1'b1;
            src_req_start_o <= 1'b1;
            src_addr_o      <= src_base_q;
            src_words_o     <= BLOCK_WORDS;
          end
        end

        SRC_REQ: begin
          if (src_ready_i) begin
            state           <= SRC_WAIT;
            src_req_start_o <= 1'b0;
          end
        end

        SRC_WAIT: begin
          if (src_done_i) begin
            state       <= RUN;
            eng_start_o <= 1'b1;
          end
        end

        RUN: begin
          if (eng_done_i) begin
            state           <= DST_REQ;
            dst_req_start_o <= 1'b1;
            dst_addr_o      <= dst_base_q + blk_offset(blk_cnt_o);
          end
        end

        DST_REQ: begin
          if (dst_ready_i) begin
            state           <= DST_WAIT;
            dst_req_start_o <= 1'b0;
          end
        end

        DST_WAIT: begin
          if (dst_done_i) begin
            blk_cnt_o <= blk_cnt_inc;
            if (blk_cnt_inc == num_blocks_q) begin
              state <= FINISH;
            end else begin
              state           <= SRC_REQ;
              src_req_start_o <= 1'b1;
              src_addr_o      <= src_base_q + blk_offset(blk_cnt_inc);
              src_words_o     <= BLOCK_WORDS;
            end
          end
        end

        FINISH: begin
          state       <= IDLE;
          done_o      <= 1'b1;
          busy_o      <= 1'b0;
          eng_clear_o <= 1'b1;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
